// File: rtl/csr_pkg.sv
// CSR access unit shared types: funct3 opcode encoding, FSM state encoding,
// the machine-mode CSR addresses recognised by the optional address check,
// and small decode helpers used by the unit and its write-data merge.
package csr_pkg;

  // funct3 field of a SYSTEM/Zicsr instruction; 000 and 100 are not CSR ops
  typedef enum logic [2:0] {
    CSR_OP_ILL0 = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_ILL4 = 3'b100,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_e;

  // Read-modify-write sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // funct3 values that do not name a CSR operation
  function automatic logic csr_op_illegal(csr_op_e op);
    return (op == CSR_OP_ILL0) || (op == CSR_OP_ILL4);
  endfunction

  // RW / RWI: plain write, the old value is only needed when rd != x0
  function automatic logic csr_op_is_swap(csr_op_e op);
    return (op == CSR_OP_RW) || (op == CSR_OP_RWI);
  endfunction

  // Immediate forms take the rs1 field as a 5-bit zero-extended value
  function automatic logic csr_op_is_imm(csr_op_e op);
    return op[2];
  endfunction

  // Addresses implemented by the CSR file when address checking is enabled
  function automatic logic csr_addr_known(logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MIE) ||
           (addr == CSR_MEPC)    || (addr == CSR_MIP);
  endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// Combinational write-data merge for Zicsr operations:
//   RW/RWI -> operand, RS/RSI -> old | operand, RC/RCI -> old & ~operand.
module csr_wdata_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e          op,
  input  logic [XLEN-1:0]  old_val,
  input  logic [XLEN-1:0]  operand,
  output logic [XLEN-1:0]  wdata
);

  // Select the merge function from the operation; unknown ops pass the operand
  always_comb begin
    wdata = operand;
    case (op)
      CSR_OP_RS, CSR_OP_RSI: wdata = old_val | operand;
      CSR_OP_RC, CSR_OP_RCI: wdata = old_val & ~operand;
      default:               wdata = operand;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: initiator side of the CSR file port. Accepts one Zicsr
// instruction at a time, sequences the read and write strobes of the
// read-modify-write, and returns the old CSR value for rd writeback.
// Optional feature macro: CSR_ADDR_CHECK_EN -- when defined, only mstatus,
// mie, mepc and mip are legal addresses; otherwise all addresses pass through.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   rs1_data,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_rd,
  output logic              csr_wr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_rd_we,
  output logic              resp_illegal
);

  csr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  csr_op_e           op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              illegal_q, illegal_d;
  logic              skip_wr_q, skip_wr_d;

  csr_op_e           req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_operand;
  logic              req_illegal;
  logic              req_skip_rd;
  logic              req_skip_wr;

  csr_op_e           alu_op;
  logic [XLEN-1:0]   alu_old;
  logic [XLEN-1:0]   alu_operand;
  logic [XLEN-1:0]   alu_wdata;

  logic              unused_inst;

  assign unused_inst = ^inst[6:0];

  // Decode the incoming instruction: operand source, illegality and which
  // phases of the read-modify-write can be skipped
  always_comb begin
    req_op      = csr_op_e'(inst[14:12]);
    req_rd      = inst[11:7];
    req_rs1     = inst[19:15];
    req_addr    = inst[20 +: ADDR_W];
    req_operand = csr_op_is_imm(req_op) ? {{(XLEN-5){1'b0}}, req_rs1} : rs1_data;
`ifdef CSR_ADDR_CHECK_EN
    req_illegal = csr_op_illegal(req_op) || !csr_addr_known(12'(req_addr));
`else
    req_illegal = csr_op_illegal(req_op);
`endif
    req_skip_rd = csr_op_is_swap(req_op) && (req_rd == 5'd0);
    req_skip_wr = !csr_op_is_swap(req_op) && (req_rs1 == 5'd0);
  end

  // The merge ALU is shared: in IDLE it prepares write data for a swap that
  // skips the read (old value is irrelevant), in READ it merges the live
  // csr_rdata so csr_wdata is already registered when WRITE starts
  always_comb begin
    alu_op      = (state_q == ST_IDLE) ? req_op : op_q;
    alu_old     = (state_q == ST_READ) ? csr_rdata : '0;
    alu_operand = (state_q == ST_IDLE) ? req_operand : operand_q;
  end

  csr_wdata_alu #(
    .XLEN (XLEN)
  ) u_wdata_alu (
    .op      (alu_op),
    .old_val (alu_old),
    .operand (alu_operand),
    .wdata   (alu_wdata)
  );

  // Next-state and datapath update for the IDLE/READ/WRITE/RESP sequencer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    rd_d      = rd_q;
    operand_d = operand_q;
    old_d     = old_q;
    wdata_d   = wdata_q;
    illegal_d = illegal_q;
    skip_wr_d = skip_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          op_d      = req_op;
          rd_d      = req_rd;
          operand_d = req_operand;
          old_d     = '0;
          illegal_d = req_illegal;
          skip_wr_d = req_skip_wr;
          if (req_illegal) begin
            state_d = ST_RESP;
          end else if (req_skip_rd) begin
            wdata_d = alu_wdata;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        old_d   = csr_rdata;
        wdata_d = alu_wdata;
        state_d = skip_wr_q ? ST_RESP : ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so strobes drop at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      op_q      <= CSR_OP_ILL0;
      rd_q      <= '0;
      operand_q <= '0;
      old_q     <= '0;
      wdata_q   <= '0;
      illegal_q <= 1'b0;
      skip_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      operand_q <= operand_d;
      old_q     <= old_d;
      wdata_q   <= wdata_d;
      illegal_q <= illegal_d;
      skip_wr_q <= skip_wr_d;
    end
  end

  // Port outputs decode straight from the state register, so each strobe is
  // exactly one cycle wide and read/write can never overlap
  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    csr_rd       = (state_q == ST_READ);
    csr_wr       = (state_q == ST_WRITE);
    csr_addr     = addr_q;
    csr_wdata    = wdata_q;
    resp_valid   = (state_q == ST_RESP);
    resp_data    = resp_valid ? old_q : '0;
    resp_rd_we   = resp_valid && (rd_q != 5'd0) && !illegal_q;
    resp_illegal = resp_valid && illegal_q;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: table of directed Zicsr
// transactions against a one-register CSR file model, plus hand-written
// sequences for response back-pressure and reset in READ / WRITE.
module tb_csr_access_unit;

   localparam int NV = 11;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] inst;
   logic [31:0] rs1_data;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_rd;
   logic        csr_wr;
   logic [31:0] csr_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_rd_we;
   logic        resp_illegal;

   logic [31:0] fileVal;
   logic [31:0] loadVal;
   logic        loadReq;

   int errors;
   int checks;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] rs1Data;
      logic [31:0] fileInit;
      logic [11:0] expAddr;
      int          expRd;
      int          expWr;
      logic [31:0] expWdata;
      int          expLat;
      logic [31:0] expData;
      logic        expWe;
      logic        expIll;
      logic [31:0] expFile;
   } vec_t;

   vec_t vecs[NV];

   csr_access_unit dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .inst         (inst),
      .rs1_data     (rs1_data),
      .csr_addr     (csr_addr),
      .csr_wdata    (csr_wdata),
      .csr_rd       (csr_rd),
      .csr_wr       (csr_wr),
      .csr_rdata    (csr_rdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_rd_we   (resp_rd_we),
      .resp_illegal (resp_illegal)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-register CSR file model: combinational read, write on the strobe
   assign csr_rdata = fileVal;
   always @(posedge clk) begin
      if (loadReq) fileVal <= loadVal;
      else if (csr_wr) fileVal <= csr_wdata;
   end

   function automatic logic [31:0] mkInst(logic [11:0] csr, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
      return {csr, rs1, f3, rd, 7'h73};
   endfunction

   // Single comparison with failure report
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Preload the CSR file model, then present one request until accepted
   task automatic applyStimulus(input logic [31:0] i, input logic [31:0] r,
                                input logic [31:0] f);
      @(negedge clk);
      loadVal = f;
      loadReq = 1'b1;
      @(negedge clk);
      loadReq   = 1'b0;
      inst      = i;
      rs1_data  = r;
      req_valid = 1'b1;
      checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // Observe strobes cycle by cycle until resp_valid, with a cycle bound
   task automatic waitResp(output int lat, output int rdCnt, output int wrCnt,
                           output logic [31:0] wdata, output int overlap);
      lat = 0; rdCnt = 0; wrCnt = 0; wdata = 32'd0; overlap = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (csr_rd && csr_wr) overlap++;
         if (resp_valid) begin
            lat = c;
            break;
         end
         if (csr_rd) rdCnt++;
         if (csr_wr) begin
            wrCnt++;
            wdata = csr_wdata;
         end
      end
      if (lat == 0) lat = 99;
   endtask

   initial begin
      int          lat, rdCnt, wrCnt, overlap;
      logic [31:0] wd;

      errors = 0; checks = 0;
      rst = 1'b0; req_valid = 1'b0; inst = 32'd0; rs1_data = 32'd0;
      resp_ready = 1'b1; loadVal = 32'd0; loadReq = 1'b0; fileVal = 32'd0;

      vecs[0]  = '{mkInst(12'h300, 5'd1, 3'b001, 5'd5), 32'hDEADBEEF, 32'h8, 12'h300,
                   1, 1, 32'hDEADBEEF, 3, 32'h8, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[1]  = '{mkInst(12'h304, 5'd0, 3'b010, 5'd0), 32'hFFFF0000, 32'h1234, 12'h304,
                   1, 0, 32'h0, 2, 32'h1234, 1'b0, 1'b0, 32'h1234};
      vecs[2]  = '{mkInst(12'h344, 5'd5, 3'b111, 5'd3), 32'h0, 32'hF, 12'h344,
                   1, 1, 32'hA, 3, 32'hF, 1'b1, 1'b0, 32'hA};
      vecs[3]  = '{mkInst(12'h300, 5'd2, 3'b100, 5'd7), 32'h55, 32'h99, 12'h300,
                   0, 0, 32'h0, 1, 32'h0, 1'b0, 1'b1, 32'h99};
`ifdef CSR_ADDR_CHECK_EN
      vecs[4]  = '{mkInst(12'h7C0, 5'd4, 3'b001, 5'd2), 32'h55, 32'h77, 12'h7C0,
                   0, 0, 32'h0, 1, 32'h0, 1'b0, 1'b1, 32'h77};
`else
      vecs[4]  = '{mkInst(12'h7C0, 5'd4, 3'b001, 5'd2), 32'h55, 32'h77, 12'h7C0,
                   1, 1, 32'h55, 3, 32'h77, 1'b1, 1'b0, 32'h55};
`endif
      vecs[5]  = '{mkInst(12'h341, 5'h1F, 3'b101, 5'd0), 32'hFFFFFFFF, 32'h3, 12'h341,
                   0, 1, 32'h1F, 2, 32'h0, 1'b0, 1'b0, 32'h1F};
      vecs[6]  = '{mkInst(12'h300, 5'd2, 3'b010, 5'd4), 32'hF0, 32'h0F, 12'h300,
                   1, 1, 32'hFF, 3, 32'h0F, 1'b1, 1'b0, 32'hFF};
      vecs[7]  = '{mkInst(12'h304, 5'd0, 3'b110, 5'd6), 32'hFFFFFFFF, 32'hABC, 12'h304,
                   1, 0, 32'h0, 2, 32'hABC, 1'b1, 1'b0, 32'hABC};
      vecs[8]  = '{mkInst(12'h341, 5'd3, 3'b000, 5'd1), 32'h1, 32'h5, 12'h341,
                   0, 0, 32'h0, 1, 32'h0, 1'b0, 1'b1, 32'h5};
      vecs[9]  = '{mkInst(12'h341, 5'd3, 3'b011, 5'd9), 32'h0000FFFF, 32'h12345678, 12'h341,
                   1, 1, 32'h12340000, 3, 32'h12345678, 1'b1, 1'b0, 32'h12340000};
      vecs[10] = '{mkInst(12'h300, 5'd8, 3'b001, 5'd0), 32'hCAFE, 32'h66, 12'h300,
                   0, 1, 32'hCAFE, 2, 32'h0, 1'b0, 1'b0, 32'hCAFE};

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("reset_csr_rd", {31'd0, csr_rd}, 32'd0);
      checkOutput("reset_csr_wr", {31'd0, csr_wr}, 32'd0);
      checkOutput("reset_csr_addr", {20'd0, csr_addr}, 32'd0);
      checkOutput("reset_csr_wdata", csr_wdata, 32'd0);
      checkOutput("reset_resp_data", resp_data, 32'd0);
      checkOutput("reset_resp_flags", {30'd0, resp_rd_we, resp_illegal}, 32'd0);
      rst = 1'b1;

      // Table-driven transactions
      for (int v = 0; v < NV; v++) begin
         applyStimulus(vecs[v].inst, vecs[v].rs1Data, vecs[v].fileInit);
         waitResp(lat, rdCnt, wrCnt, wd, overlap);
         checkOutput($sformatf("v%0d_latency", v), lat, vecs[v].expLat);
         checkOutput($sformatf("v%0d_rd_pulses", v), rdCnt, vecs[v].expRd);
         checkOutput($sformatf("v%0d_wr_pulses", v), wrCnt, vecs[v].expWr);
         if (vecs[v].expWr > 0)
            checkOutput($sformatf("v%0d_wdata", v), wd, vecs[v].expWdata);
         checkOutput($sformatf("v%0d_overlap", v), overlap, 0);
         checkOutput($sformatf("v%0d_addr", v), {20'd0, csr_addr}, {20'd0, vecs[v].expAddr});
         checkOutput($sformatf("v%0d_resp_data", v), resp_data, vecs[v].expData);
         checkOutput($sformatf("v%0d_rd_we", v), {31'd0, resp_rd_we}, {31'd0, vecs[v].expWe});
         checkOutput($sformatf("v%0d_illegal", v), {31'd0, resp_illegal}, {31'd0, vecs[v].expIll});
         checkOutput($sformatf("v%0d_file", v), fileVal, vecs[v].expFile);
         @(negedge clk);
         checkOutput($sformatf("v%0d_resp_drop", v), {31'd0, resp_valid}, 32'd0);
         checkOutput($sformatf("v%0d_ready_back", v), {31'd0, req_ready}, 32'd1);
      end

      // Back-pressure: response held for 4 cycles while a second request waits
      resp_ready = 1'b0;
      applyStimulus(mkInst(12'h300, 5'd1, 3'b001, 5'd5), 32'h11, 32'h22);
      waitResp(lat, rdCnt, wrCnt, wd, overlap);
      checkOutput("hold_latency", lat, 3);
      req_valid = 1'b1;
      inst = mkInst(12'h304, 5'd1, 3'b001, 5'd5);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput($sformatf("hold%0d_valid", k), {31'd0, resp_valid}, 32'd1);
         checkOutput($sformatf("hold%0d_data", k), resp_data, 32'h22);
         checkOutput($sformatf("hold%0d_rd_we", k), {31'd0, resp_rd_we}, 32'd1);
         checkOutput($sformatf("hold%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("hold_release_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("hold_release_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      checkOutput("hold_no_stray_rd", {31'd0, csr_rd}, 32'd0);

      // Reset during READ: no write may follow
      applyStimulus(mkInst(12'h304, 5'd1, 3'b001, 5'd5), 32'h99, 32'h44);
      @(negedge clk);
      checkOutput("rstrd_in_read", {31'd0, csr_rd}, 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("rstrd_rd_drop", {31'd0, csr_rd}, 32'd0);
      checkOutput("rstrd_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      wrCnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (csr_wr) wrCnt++;
      end
      checkOutput("rstrd_no_write", wrCnt, 0);
      checkOutput("rstrd_file", fileVal, 32'h44);

      // Reset during WRITE: strobe drops immediately
      applyStimulus(mkInst(12'h300, 5'd1, 3'b001, 5'd5), 32'h1234, 32'h5);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstwr_in_write", {31'd0, csr_wr}, 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("rstwr_wr_drop", {31'd0, csr_wr}, 32'd0);
      checkOutput("rstwr_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("rstwr_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
